// File: rtl/que_reader.sv
// que_reader: pops 256-bit entropy-queue entries and serializes them into OUT_WIDTH chunks.
// Optional build macro QUE_READER_MSB_FIRST_EN emits the most-significant chunk first.
module que_reader #(
  parameter int WIDTH     = 256,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rdata,
  input  logic                 empty,
  output logic                 deque,
  input  logic                 inter_fail,
  input  logic                 perm_fail,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 fault,
  output logic [7:0]           drop_cnt,
  output logic [1:0]           dbg_state
);

  localparam int N  = WIDTH / OUT_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             deque_c, valid_c, load, last_c;
  logic [WIDTH-1:0] shifted;

`ifdef QUE_READER_MSB_FIRST_EN
  assign out_data = shift_q[WIDTH-1 -: OUT_WIDTH];
  assign shifted  = shift_q << OUT_WIDTH;
`else
  assign out_data = shift_q[OUT_WIDTH-1:0];
  assign shifted  = shift_q >> OUT_WIDTH;
`endif

  assign load   = !empty && !inter_fail && !perm_fail;
  assign last_c = (state_q == SEND) && (cnt_q == CW'(N - 1));

  // Stream handshake: a chunk transfers on any cycle with out_valid && out_ready;
  // out_data/out_last hold while out_valid && !out_ready. out_valid never waits on out_ready.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    deque_c = 1'b0;
    valid_c = 1'b0;
    if (perm_fail) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            deque_c = 1'b1;
            shift_d = rdata;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (inter_fail) begin
            // Partial word is untrustworthy: throw away the rest of it.
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            valid_c = 1'b1;
            if (out_ready) begin
              if (last_c) begin
                if (load) begin
                  deque_c = 1'b1;
                  shift_d = rdata;
                  cnt_d   = '0;
                end else begin
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
                end
              end else begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
              end
            end
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign deque     = deque_c && !rst;
  assign out_valid = valid_c && !rst;
  assign out_last  = last_c;
  assign fault     = (state_q == FAULT);
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_que_reader.sv
// Directed bench for que_reader: a small queue model feeds rdata/empty and pops on deque.
module tb_que_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] rdata = '0;
  logic         empty = 1'b1;
  logic         deque;
  logic         inter_fail = 1'b0;
  logic         perm_fail = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         fault;
  logic [7:0]   drop_cnt;
  logic [1:0]   dbg_state;

  logic [255:0] qm[$];
  logic         deq_s;
  int           n_tests = 0;
  int           n_fail  = 0;

  que_reader #(.WIDTH(256), .OUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .empty(empty), .deque(deque),
    .inter_fail(inter_fail), .perm_fail(perm_fail),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .fault(fault), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_k(input logic [31:0] base, input int k);
    return base + 32'(k) * 32'h11111111;
  endfunction

  function automatic logic [255:0] entry(input logic [31:0] base);
    logic [255:0] e;
    for (int k = 0; k < 8; k++) e[k*32 +: 32] = word_k(base, k);
    return e;
  endfunction

  // Expected word for the i-th emitted chunk of an entry.
  function automatic logic [31:0] exp_chunk(input logic [31:0] base, input int i);
`ifdef QUE_READER_MSB_FIRST_EN
    return word_k(base, 7 - i);
`else
    return word_k(base, i);
`endif
  endfunction

  task automatic sync_q();
    if (qm.size() > 0) begin
      rdata = qm[0];
      empty = 1'b0;
    end else begin
      rdata = '0;
      empty = 1'b1;
    end
  endtask

  // Advance one clock; the queue model pops if deque was high before the edge.
  task automatic step();
    @(negedge clk);
    deq_s = deque;
    @(posedge clk);
    #1;
    if (deq_s && qm.size() > 0) void'(qm.pop_front());
    sync_q();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    #1;
    chk("rst_deque", 32'(deque), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // Empty queue for 50 cycles
    for (int c = 0; c < 50; c++) begin
      #1;
      chk("empty_deque", 32'(deque), 32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_fault", 32'(fault), 32'd0);
      chk("empty_drop", 32'(drop_cnt), 32'd0);
      step();
    end

    // Single entry, out_ready=1
    qm.push_back(entry(32'h0));
    sync_q();
    out_ready = 1'b1;
    #1;
    chk("one_pop", 32'(deque), 32'd1);
    chk("one_pop_valid", 32'(out_valid), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("one_valid", 32'(out_valid), 32'd1);
      chk("one_data", out_data, exp_chunk(32'h0, i));
      chk("one_last", 32'(out_last), 32'(i == 7));
      chk("one_deque", 32'(deque), 32'd0);
      step();
    end
    #1;
    chk("one_after_valid", 32'(out_valid), 32'd0);
    chk("one_after_deque", 32'(deque), 32'd0);

    // Two entries back to back, no bubble
    qm.push_back(entry(32'h0));
    qm.push_back(entry(32'h80000000));
    sync_q();
    #1;
    chk("two_pop0", 32'(deque), 32'd1);
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("two_valid", 32'(out_valid), 32'd1);
      chk("two_data", out_data, exp_chunk((i < 8) ? 32'h0 : 32'h80000000, i % 8));
      chk("two_last", 32'(out_last), 32'((i % 8) == 7));
      chk("two_deque", 32'(deque), 32'(i == 7));
      step();
    end
    #1;
    chk("two_after_valid", 32'(out_valid), 32'd0);
    chk("two_after_empty", 32'(qm.size()), 32'd0);

    // Backpressure after the second chunk
    qm.push_back(entry(32'h0));
    sync_q();
    #1;
    chk("bp_pop", 32'(deque), 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_pre_data", out_data, exp_chunk(32'h0, i));
      step();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, exp_chunk(32'h0, 2));
      chk("bp_hold_deque", 32'(deque), 32'd0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      #1;
      chk("bp_post_valid", 32'(out_valid), 32'd1);
      chk("bp_post_data", out_data, exp_chunk(32'h0, i));
      chk("bp_post_last", 32'(out_last), 32'(i == 7));
      step();
    end
    #1;
    chk("bp_after_valid", 32'(out_valid), 32'd0);

    // Intermittent failure during chunk 4
    qm.push_back(entry(32'h0));
    qm.push_back(entry(32'h80000000));
    sync_q();
    #1;
    chk("if_pop0", 32'(deque), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("if_pre_data", out_data, exp_chunk(32'h0, i));
      step();
    end
    inter_fail = 1'b1;
    #1;
    chk("if_valid", 32'(out_valid), 32'd0);
    chk("if_deque", 32'(deque), 32'd0);
    step();
    inter_fail = 1'b0;
    #1;
    chk("if_drop", 32'(drop_cnt), 32'd1);
    chk("if_valid_idle", 32'(out_valid), 32'd0);
    chk("if_pop1", 32'(deque), 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("if_next_valid", 32'(out_valid), 32'd1);
      chk("if_next_data", out_data, exp_chunk(32'h80000000, i));
      step();
    end
    #1;
    chk("if_drop_after", 32'(drop_cnt), 32'd1);

    // Permanent failure with the queue non-empty
    qm.push_back(entry(32'h0));
    sync_q();
    perm_fail = 1'b1;
    #1;
    chk("pf_deque", 32'(deque), 32'd0);
    chk("pf_valid", 32'(out_valid), 32'd0);
    step();
    perm_fail = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      chk("pf_fault", 32'(fault), 32'd1);
      chk("pf_hold_deque", 32'(deque), 32'd0);
      chk("pf_hold_valid", 32'(out_valid), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    #1;
    chk("pf_rst_deque", 32'(deque), 32'd0);
    rst = 1'b0;
    #1;
    chk("pf_rst_fault", 32'(fault), 32'd0);
    chk("pf_rst_drop", 32'(drop_cnt), 32'd0);
    chk("pf_resume_pop", 32'(deque), 32'd1);
    step();
    #1;
    chk("pf_resume_valid", 32'(out_valid), 32'd1);
    chk("pf_resume_data", out_data, exp_chunk(32'h0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
